// File: rtl/mul_psc_pkg.sv
// mul_psc_pkg: shared types and constants for the multiplier special-case
// pipeline. It holds the operand class enum, the select-code encodings
// and the bit positions inside the sticky flag vector.
package mul_psc_pkg;

  // Operand classes. SUB is flushed to zero by the result logic.
  typedef enum logic [2:0] {
    ZERO = 3'd0,
    SUB  = 3'd1,
    INF  = 3'd2,
    NAN  = 3'd3,
    NORM = 3'd4
  } cls_t;

  // Exponent select codes. 2'b11 is never produced.
  localparam logic [1:0] SEL_EXP_CALC = 2'b00;
  localparam logic [1:0] SEL_EXP_ONES = 2'b01;
  localparam logic [1:0] SEL_EXP_ZERO = 2'b10;

  // Mantissa select codes. 2'b11 is never produced.
  localparam logic [1:0] SEL_MAN_CALC = 2'b00;
  localparam logic [1:0] SEL_MAN_QNAN = 2'b01;
  localparam logic [1:0] SEL_MAN_ZERO = 2'b10;

  // Sticky flag layout: {invalid, nan_in, inf_out, zero_out}.
  localparam int FLAG_INVALID  = 3;
  localparam int FLAG_NAN_IN   = 2;
  localparam int FLAG_INF_OUT  = 1;
  localparam int FLAG_ZERO_OUT = 0;
  localparam int FLAG_W        = 4;

  // True for classes that behave as zero in a product (subnormals flush).
  function automatic logic is_zero_like(input cls_t c);
    return (c == ZERO) || (c == SUB);
  endfunction

endpackage

// File: rtl/mul_psc_pipe_if.sv
// mul_psc_pipe_if: input beat, output beat and flag-control signals of the
// special-case pipeline. The slave modport is the pipeline side, the
// master modport is the side feeding operands and consuming results.
interface mul_psc_pipe_if #(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24,
  parameter int LANES    = 2
);

  // Input beat
  logic                      i_valid;
  logic                      o_ready;
  logic [LANES-1:0]          i_sign_a;
  logic [LANES-1:0]          i_sign_b;
  logic [LANES*SIZE_EXP-1:0] i_exp_a;
  logic [LANES*SIZE_EXP-1:0] i_exp_b;
  logic [LANES*SIZE_MAN-1:0] i_man_a;
  logic [LANES*SIZE_MAN-1:0] i_man_b;

  // Output beat
  logic                      o_valid;
  logic                      i_ready;
  logic [2*LANES-1:0]        o_sel_exp;
  logic [2*LANES-1:0]        o_sel_man;
  logic [LANES-1:0]          o_sign;

  // Sticky flags
  logic                      i_flag_clr;
  logic [3:0]                o_flags;

  modport slave (
    input  i_valid, i_sign_a, i_sign_b, i_exp_a, i_exp_b, i_man_a, i_man_b,
    input  i_ready, i_flag_clr,
    output o_ready, o_valid, o_sel_exp, o_sel_man, o_sign, o_flags
  );

  modport master (
    output i_valid, i_sign_a, i_sign_b, i_exp_a, i_exp_b, i_man_a, i_man_b,
    output i_ready, i_flag_clr,
    input  o_ready, o_valid, o_sel_exp, o_sel_man, o_sign, o_flags
  );

endinterface

// File: rtl/mul_psc_classify.sv
// mul_psc_classify: classifies one floating-point operand from its
// exponent and fraction. The hidden mantissa bit plays no part in the
// class, so only the fraction is brought in.
module mul_psc_classify
  import mul_psc_pkg::*;
#(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24
) (
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MAN-2:0] i_frac,
  output cls_t                o_cls
);

  // Decode the class from an all-zero or all-ones exponent and the fraction.
  always_comb begin
    o_cls = NORM;
    if (i_exp == '0) begin
      o_cls = (i_frac == '0) ? ZERO : SUB;
    end else if (&i_exp) begin
      o_cls = (i_frac == '0) ? INF : NAN;
    end
  end

endmodule

// File: rtl/mul_psc_pipe.sv
// mul_psc_pipe: two-stage, multi-lane special-case resolver for a
// floating-point multiplier. S1 holds per-lane operand classes and the
// product sign; S2 holds the exponent/mantissa select codes and the
// result sign. Both stages use valid/ready with full throughput.
// Optional sticky flags are built when MUL_PSC_FLAG_EN is defined;
// otherwise o_flags is tied to zero and no flag state exists.
module mul_psc_pipe
  import mul_psc_pkg::*;
#(
  parameter int SIZE_EXP = 8,
  parameter int SIZE_MAN = 24,
  parameter int LANES    = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  mul_psc_pipe_if.slave bus
);

  // Combinational classes of the incoming beat
  cls_t cls_a [LANES];
  cls_t cls_b [LANES];

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  cls_t             s1_cls_a_q [LANES];
  cls_t             s1_cls_a_d [LANES];
  cls_t             s1_cls_b_q [LANES];
  cls_t             s1_cls_b_d [LANES];
  logic [LANES-1:0] s1_sign_q, s1_sign_d;

  // Stage 2 state
  logic               s2_valid_q, s2_valid_d;
  logic [2*LANES-1:0] s2_sel_exp_q, s2_sel_exp_d;
  logic [2*LANES-1:0] s2_sel_man_q, s2_sel_man_d;
  logic [LANES-1:0]   s2_sign_q, s2_sign_d;

  // Per-lane results derived from S1
  logic [LANES-1:0]   res_nan_in;
  logic [LANES-1:0]   res_invalid;
  logic [LANES-1:0]   res_inf;
  logic [LANES-1:0]   res_zero;
  logic [2*LANES-1:0] res_sel_exp;
  logic [2*LANES-1:0] res_sel_man;
  logic [LANES-1:0]   res_sign;

  // Handshake controls
  logic s2_load;
  logic s1_adv;

  genvar gi;

  // One classifier per operand per lane
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_cls
      mul_psc_classify #(
        .SIZE_EXP (SIZE_EXP),
        .SIZE_MAN (SIZE_MAN)
      ) u_cls_a (
        .i_exp  (bus.i_exp_a[gi*SIZE_EXP +: SIZE_EXP]),
        .i_frac (bus.i_man_a[gi*SIZE_MAN +: SIZE_MAN-1]),
        .o_cls  (cls_a[gi])
      );

      mul_psc_classify #(
        .SIZE_EXP (SIZE_EXP),
        .SIZE_MAN (SIZE_MAN)
      ) u_cls_b (
        .i_exp  (bus.i_exp_b[gi*SIZE_EXP +: SIZE_EXP]),
        .i_frac (bus.i_man_b[gi*SIZE_MAN +: SIZE_MAN-1]),
        .o_cls  (cls_b[gi])
      );
    end
  endgenerate

  // Per-lane result rules; the event terms are mutually exclusive so the
  // select logic and the flag logic can share them.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic       a_zero;
      logic       b_zero;
      logic       any_inf;
      logic [1:0] sel_e;
      logic [1:0] sel_m;
      logic       sgn;

      assign a_zero          = is_zero_like(s1_cls_a_q[gi]);
      assign b_zero          = is_zero_like(s1_cls_b_q[gi]);
      assign any_inf         = (s1_cls_a_q[gi] == INF) || (s1_cls_b_q[gi] == INF);
      assign res_nan_in[gi]  = (s1_cls_a_q[gi] == NAN) || (s1_cls_b_q[gi] == NAN);
      assign res_invalid[gi] = !res_nan_in[gi] &&
                               (((s1_cls_a_q[gi] == INF) && b_zero) ||
                                ((s1_cls_b_q[gi] == INF) && a_zero));
      assign res_inf[gi]     = !res_nan_in[gi] && !res_invalid[gi] && any_inf;
      assign res_zero[gi]    = !res_nan_in[gi] && !any_inf && (a_zero || b_zero);

      // Pick exponent/mantissa sources and sign; NaN results carry sign 0.
      always_comb begin
        sel_e = SEL_EXP_CALC;
        sel_m = SEL_MAN_CALC;
        sgn   = s1_sign_q[gi];
        if (res_nan_in[gi] || res_invalid[gi]) begin
          sel_e = SEL_EXP_ONES;
          sel_m = SEL_MAN_QNAN;
          sgn   = 1'b0;
        end else if (res_inf[gi]) begin
          sel_e = SEL_EXP_ONES;
          sel_m = SEL_MAN_ZERO;
        end else if (res_zero[gi]) begin
          sel_e = SEL_EXP_ZERO;
          sel_m = SEL_MAN_ZERO;
        end
      end

      assign res_sel_exp[2*gi +: 2] = sel_e;
      assign res_sel_man[2*gi +: 2] = sel_m;
      assign res_sign[gi]           = sgn;
    end
  endgenerate

  // Stage advance decisions and next-state for both pipeline stages
  always_comb begin
    s2_load = !s2_valid_q || bus.i_ready;
    s1_adv  = s2_load || !s1_valid_q;

    s1_valid_d = s1_valid_q;
    s1_cls_a_d = s1_cls_a_q;
    s1_cls_b_d = s1_cls_b_q;
    s1_sign_d  = s1_sign_q;
    if (s1_adv) begin
      s1_valid_d = bus.i_valid;
      if (bus.i_valid) begin
        for (int k = 0; k < LANES; k++) begin
          s1_cls_a_d[k] = cls_a[k];
          s1_cls_b_d[k] = cls_b[k];
        end
        s1_sign_d = bus.i_sign_a ^ bus.i_sign_b;
      end
    end

    s2_valid_d   = s2_valid_q;
    s2_sel_exp_d = s2_sel_exp_q;
    s2_sel_man_d = s2_sel_man_q;
    s2_sign_d    = s2_sign_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sel_exp_d = res_sel_exp;
        s2_sel_man_d = res_sel_man;
        s2_sign_d    = res_sign;
      end
    end
  end

  // Pipeline registers; reset empties both stages and clears outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_cls_a_q[k] <= ZERO;
        s1_cls_b_q[k] <= ZERO;
      end
      s2_valid_q   <= 1'b0;
      s2_sel_exp_q <= '0;
      s2_sel_man_q <= '0;
      s2_sign_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_cls_a_q   <= s1_cls_a_d;
      s1_cls_b_q   <= s1_cls_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_sel_exp_q <= s2_sel_exp_d;
      s2_sel_man_q <= s2_sel_man_d;
      s2_sign_q    <= s2_sign_d;
    end
  end

  assign bus.o_ready   = s1_adv;
  assign bus.o_valid   = s2_valid_q;
  assign bus.o_sel_exp = s2_sel_exp_q;
  assign bus.o_sel_man = s2_sel_man_q;
  assign bus.o_sign    = s2_sign_q;

`ifdef MUL_PSC_FLAG_EN
  logic [FLAG_W-1:0] beat_ev;
  logic [FLAG_W-1:0] s2_ev_q, s2_ev_d;
  logic [FLAG_W-1:0] flags_q, flags_d;

  // Events travel with the beat into S2 and only become sticky when the
  // result is actually taken; a clear never wipes bits set on that edge.
  always_comb begin
    beat_ev                = '0;
    beat_ev[FLAG_INVALID]  = |res_invalid;
    beat_ev[FLAG_NAN_IN]   = |res_nan_in;
    beat_ev[FLAG_INF_OUT]  = |res_inf;
    beat_ev[FLAG_ZERO_OUT] = |res_zero;

    s2_ev_d = s2_ev_q;
    if (s2_load && s1_valid_q) begin
      s2_ev_d = beat_ev;
    end

    flags_d = bus.i_flag_clr ? '0 : flags_q;
    if (s2_valid_q && bus.i_ready) begin
      flags_d = flags_d | s2_ev_q;
    end
  end

  // Flag registers; reset wins over clear and handshakes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_ev_q <= '0;
      flags_q <= '0;
    end else begin
      s2_ev_q <= s2_ev_d;
      flags_q <= flags_d;
    end
  end

  assign bus.o_flags = flags_q;
`else
  assign bus.o_flags = 4'b0000;
`endif

endmodule
